fifo_write_ctrl: RTL and testbench
==================================

# fifo_write_ctrl

Write-side controller of the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests from the producer and drives the write enable and pointer into the dual-port RAM. It publishes a Gray-coded write pointer for the read domain and synchronizes the read domain's Gray pointer into the write domain. From these it produces a registered full flag, an almost-full flag, a fill level and a sticky overflow error.

## Interface
- ADDR_W, 5: RAM address width; FIFO depth DEPTH = 2^ADDR_W (32).
- ALMOST_FULL_TH, 28: walmost_full asserts when the fill level is at least this value; legal range 1..DEPTH.

- clkw  in  1  write-domain clock; all state updates on its rising edge.
- resetw  in  1  synchronous, active-high reset, sampled on the rising edge of clkw.
- winc  in  1  producer write request; a write is accepted when winc=1 and wfull=0.
- rptr_gray  in  ADDR_W+1  read-domain Gray pointer; asynchronous to clkw.
- writeEnable  out  1  RAM write strobe, combinational: winc & ~wfull.
- wptr  out  ADDR_W+1  registered binary write pointer; MSB is the wrap bit; RAM address = wptr[ADDR_W-1:0].
- wptr_gray  out  ADDR_W+1  registered Gray code of wptr, sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered; wlevel >= ALMOST_FULL_TH.
- wlevel  out  ADDR_W+1  registered fill level as seen from the write side, range 0..DEPTH.
- overflow  out  1  sticky; set when winc=1 while wfull=1.

## Operation
- Synchronizer: two flops rq1 and rq2, both clocked by clkw. Each edge: rq1 <= rptr_gray, rq2 <= rq1. No other logic reads rptr_gray directly.
- Read pointer conversion: rbin_s = gray2bin(rq2), where bit i is the XOR of rq2 bits i..ADDR_W.
- Next-state values, all computed combinationally:
  - wbin_next = wptr + writeEnable, modulo 2^(ADDR_W+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - lvl_next = wbin_next - rbin_s, modulo 2^(ADDR_W+1).
- Registered outputs, updated every edge when not in reset:
  - wptr <= wbin_next and wptr_gray <= wgray_next.
  - wfull <= (wgray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
  - wlevel <= lvl_next.
  - walmost_full <= (lvl_next >= ALMOST_FULL_TH).
- Invariant: wfull == (wlevel == DEPTH) on every cycle.
- Full and level are pessimistic: a read becomes visible only after the synchronizer delay. The controller never reports fewer entries than are actually stored, so no entry is ever overwritten.
- Overflow: winc=1 while wfull=1 means the write is dropped: writeEnable=0 and wptr holds. overflow <= 1 and stays 1 until resetw.
- Wrap-around: wptr counts 0..2^(ADDR_W+1)-1 and rolls over to 0. The address wraps every DEPTH writes; the MSB toggles on each address wrap.
- Reset: resetw=1 at an edge clears wptr, wptr_gray, rq1, rq2, wfull, walmost_full, wlevel and overflow to 0. This applies in any state, including mid-burst and while full.
  - writeEnable is forced to 0 while resetw=1.
  - A winc arriving in the same cycle as reset is ignored.
  - The read domain must be reset in the same system reset event; the controller does not detect a one-sided reset.

## Timing
- Write acceptance has zero latency: writeEnable is high in the cycle where winc=1 and wfull=0. The RAM stores the data at address wptr[ADDR_W-1:0] on that same edge, and wptr advances on that edge.
- wfull, wlevel and walmost_full reflect an accepted write one edge later, i.e. they are updated on the same edge as wptr.
- Read-side visibility: a rptr_gray change that is stable before edge k is captured in rq1 at k and in rq2 at k+1. wfull, wlevel and walmost_full reflect it at edge k+2.
- rptr_gray is Gray coded, so at most one bit changes per read-clock edge. A flop that samples metastably resolves to either the old or the new pointer, both of which are safe.
- Simultaneous write and read visibility in the same cycle: the level changes by the net difference. Example: with wlevel=32 and one read reaching rq2, a write accepted in the same cycle is not allowed because wfull is still 1.

## Test plan
- Reset: hold resetw for 2 edges with winc=1 and rptr_gray=6'b000011. Required: all outputs 0, writeEnable=0, and wlevel=0 after release.
- Fill: with rptr_gray=0, assert winc for 32 cycles. Required: writeEnable high for exactly 32 cycles; wptr=6'd32 and wptr_gray=6'b110000; wfull=1 and wlevel=32 on the edge of the 32nd write; walmost_full=1 from the edge of the 28th write.
- Overflow: continue winc=1 while full. Required: writeEnable=0, wptr stays at 32, and overflow=1 from the next edge and remains 1 until resetw.
- Drain visibility: while full, set rptr_gray=6'b000110 (binary 4) before edge k. Required: wfull=0 and wlevel=28 at edge k+2, with walmost_full still 1; a write at k+3 gives wlevel=29.
- Wrap-around: run 100 writes interleaved with read-pointer updates, stepping rptr_gray through Gray values. Required: wptr rolls 63 -> 0, the address sequence is 31 -> 0 at each wrap, the wlevel invariant holds, and wfull is never set while wlevel < 32.
- Mid-operation reset: assert resetw for one edge at wlevel=17. Required: all state returns to 0 on that edge, and writes resume at address 0.

Source files
------------

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an asynchronous FIFO: accepts producer writes, advances the
// binary/Gray write pointers, and derives full / almost-full / level from the synchronized read pointer.
module fifo_write_ctrl #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned ALMOST_FULL_TH = 28
) (
    input  logic              clkw,
    input  logic              resetw,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray,
    output logic              writeEnable,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    localparam logic [ADDR_W:0] AF_TH = (ADDR_W + 1)'(ALMOST_FULL_TH);

    logic [ADDR_W:0] rq1_q, rq1_d;
    logic [ADDR_W:0] rq2_q, rq2_d;
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] wptr_gray_q, wptr_gray_d;
    logic            wfull_q, wfull_d;
    logic            walmost_full_q, walmost_full_d;
    logic [ADDR_W:0] wlevel_q, wlevel_d;
    logic            overflow_q, overflow_d;

    logic            write_en;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] full_cmp;

    // A write is accepted only when not full; reset masks the strobe so a
    // request coinciding with reset never reaches the RAM.
    assign write_en = winc & ~wfull_q & ~resetw;

    always_comb begin
        rbin_s = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            rbin_s[i] = ^(rq2_q >> i);
        end
    end

    // Full when the next write pointer equals the read pointer with its two
    // top Gray bits inverted (same address, opposite wrap).
    assign full_cmp = {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]};

    always_comb begin
        rq1_d          = rptr_gray;
        rq2_d          = rq1_q;
        wptr_d         = wptr_q + {{ADDR_W{1'b0}}, write_en};
        wptr_gray_d    = wptr_d ^ (wptr_d >> 1);
        wlevel_d       = wptr_d - rbin_s;
        wfull_d        = (wptr_gray_d == full_cmp);
        walmost_full_d = (wlevel_d >= AF_TH);
        overflow_d     = overflow_q | (winc & wfull_q);
    end

    always_ff @(posedge clkw) begin
        if (resetw) begin
            rq1_q          <= '0;
            rq2_q          <= '0;
            wptr_q         <= '0;
            wptr_gray_q    <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            overflow_q     <= 1'b0;
        end else begin
            rq1_q          <= rq1_d;
            rq2_q          <= rq2_d;
            wptr_q         <= wptr_d;
            wptr_gray_q    <= wptr_gray_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            overflow_q     <= overflow_d;
        end
    end

    assign writeEnable  = write_en;
    assign wptr         = wptr_q;
    assign wptr_gray    = wptr_gray_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Directed bench for fifo_write_ctrl: reset, fill, overflow, drain visibility,
// wrap-around with a moving read pointer, and mid-operation reset.
module tb_fifo_write_ctrl;

    logic       clkw;
    logic       resetw;
    logic       winc;
    logic [5:0] rptr_gray;
    logic       writeEnable;
    logic [5:0] wptr;
    logic [5:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [5:0] wlevel;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    fifo_write_ctrl #(.ADDR_W(5), .ALMOST_FULL_TH(28)) dut (
        .clkw         (clkw),
        .resetw       (resetw),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .writeEnable  (writeEnable),
        .wptr         (wptr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .overflow     (overflow)
    );

    initial clkw = 1'b0;
    always #5 clkw = ~clkw;

    task automatic tick();
        @(posedge clkw);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] gray6(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        int unsigned wcount;
        int unsigned rcount;
        int unsigned writes;
        int unsigned cycles;
        logic [5:0]  m_rq1;
        logic [5:0]  m_rq2;
        logic [5:0]  lvl;
        logic [5:0]  prev_wptr;
        logic        m_full;
        logic        exp_we;
        logic        seen_wrap;

        // Reset with a pending write and a non-zero read pointer
        resetw    = 1'b1;
        winc      = 1'b1;
        rptr_gray = 6'b000011;
        #1;
        chk("rst_we", 32'(writeEnable), 32'd0);
        tick();
        tick();
        chk("rst_we2", 32'(writeEnable), 32'd0);
        chk("rst_wptr", 32'(wptr), 32'd0);
        chk("rst_wgray", 32'(wptr_gray), 32'd0);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_afull", 32'(walmost_full), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        resetw    = 1'b0;
        winc      = 1'b0;
        rptr_gray = 6'd0;
        tick();
        chk("rel_wlevel", 32'(wlevel), 32'd0);
        chk("rel_wptr", 32'(wptr), 32'd0);

        // Fill 32 entries
        for (int i = 0; i < 32; i++) begin
            winc = 1'b1;
            #1;
            chk("fill_we", 32'(writeEnable), 32'd1);
            chk("fill_addr", 32'(wptr), 32'(i));
            tick();
            chk("fill_wptr", 32'(wptr), 32'(i + 1));
            chk("fill_wlevel", 32'(wlevel), 32'(i + 1));
            chk("fill_wfull", 32'(wfull), (i == 31) ? 32'd1 : 32'd0);
            chk("fill_afull", 32'(walmost_full), (i + 1 >= 28) ? 32'd1 : 32'd0);
        end
        chk("full_wptr", 32'(wptr), 32'd32);
        chk("full_wgray", 32'(wptr_gray), 32'b110000);
        chk("full_ovf0", 32'(overflow), 32'd0);

        // Overflow while full
        #1;
        chk("ovf_we", 32'(writeEnable), 32'd0);
        tick();
        chk("ovf_wptr", 32'(wptr), 32'd32);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_wfull", 32'(wfull), 32'd1);
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_wptr2", 32'(wptr), 32'd32);

        // Drain visibility: read pointer moves to 4 before edge k
        winc      = 1'b0;
        rptr_gray = 6'b000110;
        tick();
        chk("drn_k_full", 32'(wfull), 32'd1);
        chk("drn_k_lvl", 32'(wlevel), 32'd32);
        tick();
        chk("drn_k1_full", 32'(wfull), 32'd1);
        chk("drn_k1_lvl", 32'(wlevel), 32'd32);
        tick();
        chk("drn_k2_full", 32'(wfull), 32'd0);
        chk("drn_k2_lvl", 32'(wlevel), 32'd28);
        chk("drn_k2_afull", 32'(walmost_full), 32'd1);
        winc = 1'b1;
        #1;
        chk("drn_we", 32'(writeEnable), 32'd1);
        tick();
        chk("drn_k3_lvl", 32'(wlevel), 32'd29);
        chk("drn_k3_wptr", 32'(wptr), 32'd33);

        // Wrap-around: continuous writes, read advancing two cycles out of three
        wcount    = 33;
        rcount    = 4;
        m_rq1     = 6'd4;
        m_rq2     = 6'd4;
        m_full    = 1'b0;
        writes    = 0;
        cycles    = 0;
        seen_wrap = 1'b0;
        while (writes < 100 && cycles < 400) begin
            if ((cycles % 3) != 0 && rcount < wcount) rcount++;
            rptr_gray = gray6(6'(rcount));
            winc      = 1'b1;
            #1;
            exp_we = ~m_full;
            chk("wrap_we", 32'(writeEnable), 32'(exp_we));
            chk("wrap_addr", 32'(wptr[4:0]), 32'(wcount % 32));
            prev_wptr = wptr;
            tick();
            if (exp_we) begin
                wcount++;
                writes++;
            end
            lvl    = 6'(wcount) - m_rq2;
            m_full = (lvl == 6'd32);
            m_rq2  = m_rq1;
            m_rq1  = 6'(rcount);
            chk("wrap_wptr", 32'(wptr), 32'(wcount % 64));
            chk("wrap_wgray", 32'(wptr_gray), 32'(gray6(6'(wcount))));
            chk("wrap_wlevel", 32'(wlevel), 32'(lvl));
            chk("wrap_wfull", 32'(wfull), 32'(m_full));
            chk("wrap_afull", 32'(walmost_full), (lvl >= 6'd28) ? 32'd1 : 32'd0);
            chk("wrap_invar", 32'(wfull), (wlevel == 6'd32) ? 32'd1 : 32'd0);
            if (prev_wptr == 6'd63 && wptr == 6'd0) seen_wrap = 1'b1;
            cycles++;
        end
        chk("wrap_writes", 32'(writes), 32'd100);
        chk("wrap_seen", 32'(seen_wrap), 32'd1);
        chk("wrap_ovf", 32'(overflow), 32'd1);

        // Clean reset, then fill to 17 and reset mid-operation
        resetw    = 1'b1;
        winc      = 1'b0;
        rptr_gray = 6'd0;
        tick();
        resetw = 1'b0;
        chk("rst2_ovf", 32'(overflow), 32'd0);
        chk("rst2_wptr", 32'(wptr), 32'd0);
        tick();
        for (int i = 0; i < 17; i++) begin
            winc = 1'b1;
            tick();
        end
        winc = 1'b0;
        tick();
        chk("mid_lvl17", 32'(wlevel), 32'd17);
        chk("mid_wptr17", 32'(wptr), 32'd17);
        resetw = 1'b1;
        winc   = 1'b1;
        #1;
        chk("mid_rst_we", 32'(writeEnable), 32'd0);
        tick();
        chk("mid_wptr", 32'(wptr), 32'd0);
        chk("mid_wgray", 32'(wptr_gray), 32'd0);
        chk("mid_wlevel", 32'(wlevel), 32'd0);
        chk("mid_wfull", 32'(wfull), 32'd0);
        chk("mid_afull", 32'(walmost_full), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        resetw = 1'b0;
        #1;
        chk("resume_we", 32'(writeEnable), 32'd1);
        chk("resume_addr", 32'(wptr), 32'd0);
        tick();
        chk("resume_wptr", 32'(wptr), 32'd1);
        chk("resume_lvl", 32'(wlevel), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
